// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder
// Description : Single-outstanding data-memory responder for a core test
//               harness. It accepts one load/store request at a time. The
//               response comes WAIT_CYCLES+1 cycles after the accept edge.
//               Stores commit with per-byte-lane enables. Stores to
//               TOHOST_ADDR go to a mailbox register, and the first such
//               store latches the sticky test_done/test_pass flags.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   DEPTH        number of 32-bit memory words (power of two, >= 4)
//   WAIT_CYCLES  wait states between accept and response (0..7)
//   TOHOST_ADDR  byte address of the test mailbox
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-low reset
//   req_valid    request present          req_ready  request accepted this cycle
//   req_we       1 = store, 0 = load      req_addr   byte address
//   req_wdata    lane-aligned store data  req_be     byte-lane enables
//   rsp_valid    one-cycle response pulse rsp_rdata  load data (0 otherwise)
//   rsp_err      error flag (with rsp_valid)
//   test_done    sticky: first mailbox store seen
//   test_pass    sticky: first mailbox word was 3
// Build option
//   DMEM_MISALIGN_CHECK_EN  when defined, illegal byte-enable patterns or
//                           addresses misaligned to them respond with
//                           rsp_err = 1, no write and zero read data.
// ============================================================================
module dmem_responder #(
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter logic [31:0] TOHOST_ADDR = 32'd96
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        test_done,
  output logic        test_pass
);

  localparam int unsigned AW       = $clog2(DEPTH);
  // The wait counter is loaded on accept so that WAIT lasts exactly
  // WAIT_CYCLES cycles before RESP.
  localparam logic [2:0]  CNT_INIT = (WAIT_CYCLES > 0) ? 3'(WAIT_CYCLES - 1) : 3'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q,   cnt_d;
  logic [31:0] addr_q,  addr_d;
  logic        we_q,    we_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q,    be_d;
  logic [31:0] mbox_q,  mbox_d;
  logic        done_q,  done_d;
  logic        pass_q,  pass_d;

  // Memory contents deliberately survive reset, so the array has no reset.
  logic [31:0] mem [DEPTH];

  logic          in_resp;
  logic          mbox_hit;
  logic          misalign;
  logic          mem_wr;
  logic [AW-1:0] word_idx;
  logic [31:0]   rd_word;

  // Upper address bits are ignored for memory, so accesses wrap on DEPTH*4.
  assign word_idx = addr_q[AW+1:2];
  assign in_resp  = (state_q == RESP);
  assign mbox_hit = (addr_q == TOHOST_ADDR);

`ifdef DMEM_MISALIGN_CHECK_EN
  logic [1:0] lane_lo;
  logic       be_legal;

  // lane_lo is the lowest enabled lane. The address offset must match it.
  always_comb begin
    be_legal = 1'b1;
    lane_lo  = 2'd0;
    case (be_q)
      4'b0001, 4'b0011, 4'b1111: lane_lo = 2'd0;
      4'b0010:                   lane_lo = 2'd1;
      4'b0100, 4'b1100:          lane_lo = 2'd2;
      4'b1000:                   lane_lo = 2'd3;
      default:                   be_legal = 1'b0;
    endcase
  end

  assign misalign = !be_legal || (addr_q[1:0] != lane_lo);
`else
  assign misalign = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // FSM and request capture
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    mbox_d  = mbox_q;
    done_d  = done_q;
    pass_d  = pass_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          we_d    = req_we;
          wdata_d = req_wdata;
          be_d    = req_be;
          cnt_d   = CNT_INIT;
          state_d = (WAIT_CYCLES > 0) ? WAIT : RESP;
        end
      end
      WAIT: begin
        if (cnt_q == 3'd0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
        // Mailbox stores replace the whole word. Only the first one
        // decides the sticky flags.
        if (we_q && mbox_hit && !misalign) begin
          mbox_d = wdata_q;
          if (!done_q) begin
            done_d = 1'b1;
            pass_d = (wdata_q == 32'd3);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      addr_q  <= 32'd0;
      we_q    <= 1'b0;
      wdata_q <= 32'd0;
      be_q    <= 4'd0;
      mbox_q  <= 32'd0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      mbox_q  <= mbox_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  // --------------------------------------------------------------------------
  // Memory array
  // --------------------------------------------------------------------------
  // The write commits at the edge that ends RESP. An asynchronous reset
  // during WAIT or RESP forces state_q to IDLE first, so an aborted store
  // never reaches the array.
  assign mem_wr = in_resp && we_q && !mbox_hit && !misalign;

  always_ff @(posedge clk) begin
    if (mem_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (be_q[i]) begin
          mem[word_idx][8*i +: 8] <= wdata_q[8*i +: 8];
        end
      end
    end
  end

  assign rd_word = mbox_hit ? mbox_q : mem[word_idx];

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign req_ready = (state_q == IDLE);
  assign rsp_valid = in_resp;
  assign rsp_err   = in_resp && misalign;
  assign rsp_rdata = (in_resp && !we_q && !misalign) ? rd_word : 32'd0;
  assign test_done = done_q;
  assign test_pass = pass_q;

endmodule
`default_nettype wire
